// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store controller between the EX/MEM stage and the data memory.
// Accepts one request at a time. Loads are extended to 64 bits. Doubleword stores
// write directly. Byte, half and word stores read, merge and write back the whole
// 8-byte memory word. Accesses past the top of memory are faulted without any
// memory traffic.
//
// Ports:
//   clk, reset_n                    clock, asynchronous active-low reset
//   req_valid / req_ready           request handshake
//   req_load, req_store, funct3     request kind and RV64 size code
//   addr, store_data                byte address and store value
//   resp_valid, resp_fault          one-cycle completion pulse and fault flag
//   load_data                       extended load result; holds between loads
//   mem_addr, mem_write_data        data memory address and write value
//   mem_read, mem_write             data memory strobes
//   mem_read_data                   combinational read data at mem_addr
module lsu_mem_ctrl #(
    parameter int unsigned MEM_BYTES = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_load,
    input  logic        req_store,
    input  logic [2:0]  funct3,
    input  logic [63:0] addr,
    input  logic [63:0] store_data,
    output logic        resp_valid,
    output logic        resp_fault,
    output logic [63:0] load_data,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_write_data,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [63:0] mem_read_data
);

    localparam int unsigned XLEN      = 64;
    localparam logic [63:0] TOP_BASE  = 64'(MEM_BYTES - 8);
    localparam logic [63:0] MEM_LIMIT = 64'(MEM_BYTES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LD_RD,
        ST_RMW_RD,
        ST_WR,
        ST_RESP
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [2:0]      r_funct3;
    logic            r_fault;
    logic [63:0]     r_base;
    logic [2:0]      r_off;
    logic [XLEN-1:0] r_store_data;
    logic [XLEN-1:0] r_wbuf;
    logic [XLEN-1:0] r_load_data;

    logic            w_accept;
    logic [63:0]     w_size;
    logic [63:0]     w_base;
    logic [2:0]      w_off;
    logic            w_fault;
    logic [5:0]      w_shift;
    logic [XLEN-1:0] w_mask;
    logic [XLEN-1:0] w_rd_shift;

    // Low-order byte mask for an access of the given size code.
    function automatic logic [XLEN-1:0] size_mask(input logic [1:0] sz);
        logic [XLEN-1:0] m;
        case (sz)
            2'd0:    m = 64'h0000_0000_0000_00FF;
            2'd1:    m = 64'h0000_0000_0000_FFFF;
            2'd2:    m = 64'h0000_0000_FFFF_FFFF;
            default: m = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        return m;
    endfunction

    // Truncate to the access size, then sign- or zero-extend by funct3.
    function automatic logic [XLEN-1:0] extend(input logic [2:0] f3, input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        case (f3)
            3'b000:  r = {{56{v[7]}},  v[7:0]};
            3'b001:  r = {{48{v[15]}}, v[15:0]};
            3'b010:  r = {{32{v[31]}}, v[31:0]};
            3'b100:  r = {56'd0, v[7:0]};
            3'b101:  r = {48'd0, v[15:0]};
            3'b110:  r = {32'd0, v[31:0]};
            default: r = v;
        endcase
        return r;
    endfunction

    // Request decode: accesses near the top are clamped to the last full
    // 8-byte window and addressed inside it by a byte offset.
    assign w_accept = req_valid & req_ready;
    assign w_size   = 64'(1) << funct3[1:0];
    assign w_base   = (addr <= TOP_BASE) ? addr : TOP_BASE;
    assign w_off    = 3'(addr - w_base);

    // Range test written as addr > limit - size so it cannot overflow.
    assign w_fault  = (addr > (MEM_LIMIT - w_size))
                    | (funct3 == 3'b111)
                    | (req_store & funct3[2])
                    | (req_load == req_store);

    // Byte-lane alignment of the latched request within the memory word.
    assign w_shift    = {r_off, 3'b000};
    assign w_mask     = size_mask(r_funct3[1:0]) << w_shift;
    assign w_rd_shift = mem_read_data >> w_shift;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and Moore output decode.
    always_comb begin
        w_next     = r_state;
        req_ready  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        resp_valid = 1'b0;
        resp_fault = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = reset_n;
                if (w_accept) begin
                    if (w_fault) begin
                        w_next = ST_RESP;
                    end else if (req_load) begin
                        w_next = ST_LD_RD;
                    end else if (funct3[1:0] == 2'b11) begin
                        w_next = ST_WR;
                    end else begin
                        w_next = ST_RMW_RD;
                    end
                end
            end
            ST_LD_RD: begin
                mem_read = 1'b1;
                w_next   = ST_RESP;
            end
            ST_RMW_RD: begin
                mem_read = 1'b1;
                w_next   = ST_WR;
            end
            ST_WR: begin
                mem_write = 1'b1;
                w_next    = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_fault = r_fault;
                w_next     = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Request latch, write buffer and load result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_funct3     <= 3'd0;
            r_fault      <= 1'b0;
            r_base       <= 64'd0;
            r_off        <= 3'd0;
            r_store_data <= '0;
            r_wbuf       <= '0;
            r_load_data  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_funct3 <= funct3;
                        r_fault  <= w_fault;
                        // Faulted requests leave the memory-side address untouched.
                        if (!w_fault) begin
                            r_base       <= w_base;
                            r_off        <= w_off;
                            r_store_data <= store_data;
                            if (req_store && (funct3[1:0] == 2'b11)) begin
                                r_wbuf <= store_data;
                            end
                        end
                    end
                end
                ST_LD_RD: begin
                    r_load_data <= extend(r_funct3, w_rd_shift);
                end
                ST_RMW_RD: begin
                    r_wbuf <= (mem_read_data & ~w_mask) | ((r_store_data << w_shift) & w_mask);
                end
                default: begin
                end
            endcase
        end
    end

    assign load_data      = r_load_data;
    assign mem_addr       = r_base;
    assign mem_write_data = r_wbuf;

endmodule
